// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and holds the IF/ID register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_pc,
    input  logic        hazard,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] stall_cnt,
    output logic [31:0] bubble_cnt
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} fetch_state_t;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc4_q, pc4_d;
    logic         valid_q, valid_d;
    logic         load_bubble;
    logic         frozen;

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;
        load_bubble = 1'b0;
        frozen      = 1'b0;
        if (redirect_valid) begin
            // Masking keeps the target word-aligned; the fetched wrong-path word is dropped.
            pc_d        = redirect_pc & 32'hFFFF_FFFC;
            load_bubble = 1'b1;
        end else if (!en_pc) begin
            frozen = 1'b1;
        end else if (hazard || !imem_valid) begin
            load_bubble = 1'b1;
        end else begin
            instr_d = imem_rdata;
            pc4_d   = pc_q + 32'd4;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
        end
        if (load_bubble) begin
            instr_d = NOP_INSTR;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     if (!en_pc) state_d = HOLD;
                HOLD:    if (en_pc)  state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            if (frozen)      stall_cnt_q  <= stall_cnt_q + 32'd1;
            if (load_bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = frozen ^ load_bubble;
    assign stall_cnt   = 32'd0;
    assign bubble_cnt  = 32'd0;
`endif

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; instruction memory returns ~addr.
// Counter expectations follow FETCH_PERF_CNT_EN.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_pc;
    logic        hazard;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = ~imem_addr;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .en_pc          (en_pc),
        .hazard         (hazard),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_valid     (imem_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc4      (if_id_pc4),
        .if_id_valid    (if_id_valid),
        .stall_cnt      (stall_cnt),
        .bubble_cnt     (bubble_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef FETCH_PERF_CNT_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_if(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid);
        check({tag, ".addr"},  imem_addr,   addr);
        check({tag, ".instr"}, if_id_instr, instr);
        check({tag, ".pc4"},   if_id_pc4,   pc4);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    endtask

    initial begin
        rst = 1'b1; en_pc = 1'b1; hazard = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'd0; imem_valid = 1'b1;
        #2;
        step();
        check_if("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        check("reset.stall",  stall_cnt,  32'd0);
        check("reset.bubble", bubble_cnt, 32'd0);

        rst = 1'b0;
        step(); check_if("seq0", 32'h4, 32'hFFFF_FFFF, 32'h4, 1'b1);
        step(); check_if("seq1", 32'h8, 32'hFFFF_FFFB, 32'h8, 1'b1);
        step(); check_if("seq2", 32'hC, 32'hFFFF_FFF7, 32'hC, 1'b1);
        step(); check_if("seq3", 32'h10, 32'hFFFF_FFF3, 32'h10, 1'b1);

        en_pc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); check_if("freeze", 32'h10, 32'hFFFF_FFF3, 32'h10, 1'b1);
        end
        check("freeze.stall", stall_cnt, perf(32'd3));
        en_pc = 1'b1;
        step(); check_if("resume", 32'h14, 32'hFFFF_FFEF, 32'h14, 1'b1);
        step(); step(); step();
        check_if("to20", 32'h20, 32'hFFFF_FFE3, 32'h20, 1'b1);

        hazard = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(); check_if("hazard", 32'h20, 32'h0, 32'h0, 1'b0);
        end
        check("hazard.bubble", bubble_cnt, perf(32'd2));
        hazard = 1'b0;
        step(); check_if("post_haz", 32'h24, 32'hFFFF_FFDF, 32'h24, 1'b1);

        en_pc = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
        #1;
        check("addr_not_comb", imem_addr, 32'h24);
        step(); check_if("redirect", 32'h100, 32'h0, 32'h0, 1'b0);
        check("redir.bubble", bubble_cnt, perf(32'd3));
        check("redir.stall",  stall_cnt,  perf(32'd3));
        redirect_valid = 1'b0; en_pc = 1'b1;
        step(); check_if("target", 32'h104, 32'hFFFF_FEFF, 32'h104, 1'b1);

        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        step(); check_if("redir_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        redirect_valid = 1'b0;
        step(); check_if("wrap", 32'h0, 32'h3, 32'h0, 1'b1);
        step(); check_if("post_wrap", 32'h4, 32'hFFFF_FFFF, 32'h4, 1'b1);

        en_pc = 1'b0;
        step(); check_if("hold", 32'h4, 32'hFFFF_FFFF, 32'h4, 1'b1);
        check("hold.stall", stall_cnt, perf(32'd4));
        rst = 1'b1;
        step(); check_if("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0);
        check("rst_hold.stall",  stall_cnt,  32'd0);
        check("rst_hold.bubble", bubble_cnt, 32'd0);
        rst = 1'b0; en_pc = 1'b1; imem_valid = 1'b0;
        step(); check_if("no_imem", 32'h0, 32'h0, 32'h0, 1'b0);
        check("no_imem.bubble", bubble_cnt, perf(32'd1));
        imem_valid = 1'b1;
        step(); check_if("after_rst", 32'h4, 32'hFFFF_FFFF, 32'h4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
